// File: rtl/reg_dump_if.sv
// Register-dump bus: dump control, register-file read port and the output word stream.
interface reg_dump_if #(parameter int n = 8);
    logic         start;
    logic         abort;
    logic [4:0]   first_addr;
    logic [4:0]   last_addr;
    logic [4:0]   raddr;
    logic [n-1:0] rdata;
    logic [n-1:0] out_data;
    logic [4:0]   out_addr;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         done;

    modport master (
        input  start, abort, first_addr, last_addr, rdata, out_ready,
        output raddr, out_data, out_addr, out_valid, out_last, busy, done
    );

    modport slave (
        output start, abort, first_addr, last_addr, rdata, out_ready,
        input  raddr, out_data, out_addr, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/reg_dump.sv
// Walks register indices first..last (wrapping at 31) and streams each value out
// with a valid/ready handshake; one word per two clocks at best.
module reg_dump #(
    parameter int n = 8
) (
    input  logic       clk,
    input  logic       reset,
    reg_dump_if.master bus
);

    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

    typedef struct packed {
        logic [n-1:0] data;
        logic [4:0]   addr;
        logic         valid;
        logic         last;
    } word_t;

    state_t     state, state_d;
    word_t      word_q;
    logic [4:0] raddr_q;
    logic [4:0] last_q;
    logic       done_q;

    logic load, capture, advance, finish, drop;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // abort outranks both start and a handshake seen in the same cycle
    always_comb begin
        state_d = state;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: if (bus.start && !bus.abort) begin
                load    = 1'b1;
                state_d = READ;
            end
            READ: if (bus.abort) begin
                drop    = 1'b1;
                state_d = IDLE;
            end else begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (bus.abort) begin
                drop    = 1'b1;
                state_d = IDLE;
            end else if (word_q.valid && bus.out_ready) begin
                if (word_q.last) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            raddr_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                raddr_q <= bus.first_addr;
                last_q  <= bus.last_addr;
            end
            if (capture) begin
                word_q.data  <= bus.rdata;
                word_q.addr  <= raddr_q;
                word_q.valid <= 1'b1;
                word_q.last  <= (raddr_q == last_q);
            end
            if (advance) raddr_q <= raddr_q + 5'd1;
            if (advance || finish || drop) begin
                word_q.valid <= 1'b0;
                word_q.last  <= 1'b0;
            end
        end
    end

    assign bus.raddr     = raddr_q;
    assign bus.out_data  = word_q.data;
    assign bus.out_addr  = word_q.addr;
    assign bus.out_valid = word_q.valid;
    assign bus.out_last  = word_q.last;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter: n, default 8, data width; matches the register-file data width.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 start  input  1  request a dump; sampled only in IDLE.
REQ-005 abort  input  1  cancel the dump in progress; return to IDLE, no done pulse.
REQ-006 first_addr  input  5  first register index to read; latched on an accepted start.
REQ-007 last_addr  input  5  final register index to read; latched on an accepted start.
REQ-008 raddr  output  5  read address driven to the register-file read port.
REQ-009 rdata  input  n  combinational read data for raddr, valid in the same cycle (%0 reads 0).
REQ-010 out_data  output  n  captured register value.
REQ-011 out_addr  output  5  register index of out_data.
REQ-012 out_valid  output  1  out_data/out_addr valid.
REQ-013 out_ready  input  1  sink accepts the word when out_valid && out_ready at posedge clk.
REQ-014 out_last  output  1  high with out_valid when out_addr == latched last_addr.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-017 FSM states SHALL be IDLE, READ and HOLD only.
REQ-018 IDLE, start=1: latch first/last, set raddr=first_addr, go to READ; busy rises on the next cycle.
REQ-019 READ: capture out_data<=rdata and out_addr<=raddr, assert out_valid, go to HOLD; latency from start edge to out_valid high SHALL be 2 clocks.
REQ-020 HOLD, out_valid && !out_ready: out_data, out_addr, out_valid and out_last SHALL hold stable.
REQ-021 HOLD, handshake when out_addr != last: deassert out_valid, raddr<=raddr+1 modulo 32, go to READ.
REQ-022 HOLD, handshake when out_addr == last: deassert out_valid, pulse done for 1 cycle, go to IDLE.
REQ-023 Throughput SHALL be 1 word per 2 clocks when out_ready is held high.
REQ-024 Address increment SHALL wrap 31->0; when last_addr < first_addr, the sequence is first..31, 0..last.
REQ-025 first_addr == last_addr SHALL yield exactly 1 word, with out_last=1.
REQ-026 A sequence that includes index 0 SHALL emit out_data=0 for that index (forwarded from rdata, not forced).
REQ-027 start while busy SHALL be ignored; first_addr/last_addr changes while busy SHALL have no effect.
REQ-028 abort SHALL take priority over start and over the handshake: next state IDLE, out_valid=0, done=0; a handshake in the abort cycle is not counted.
REQ-029 start and abort both high in IDLE: remain in IDLE.
REQ-030 done and out_valid SHALL never be high in the same cycle.
REQ-031 raddr SHALL hold its last value in IDLE; no write-side signals exist (read-only master).

Reset
REQ-032 reset SHALL take priority over all inputs, including mid-dump.
REQ-033 On reset: state=IDLE, raddr=0, out_data=0, out_addr=0, out_valid=0, out_last=0, busy=0, done=0, latched first/last=0.
REQ-034 The first start is accepted on the cycle after reset deasserts.

Verification
REQ-035 Reg file preloaded gpr[k]=k+8'h10; start first=1, last=3, out_ready=1 -> words (1,11h),(2,12h),(3,13h); out_last only on 3; done 1 cycle after the 3rd handshake; out_valid first high 2 clocks after start.
REQ-036 first=30, last=1 -> out_addr sequence 30,31,0,1 with out_data at index 0 = 0; 4 words total.
REQ-037 first=last=5 with out_ready=0 for 4 cycles, then 1 -> a single word (5,15h) held stable for all 4 stall cycles; out_last=1; then done.
REQ-038 abort asserted in HOLD on the 2nd word of 0..7 -> out_valid=0 next cycle, busy=0, done never pulses; a new start 0..0 then completes normally.
REQ-039 reset asserted mid-dump (READ and HOLD cases) -> all outputs 0 next cycle; start asserted while busy changes neither the sequence nor the latched bounds.
